// File: rtl/demux_1.sv
// Registered 1-to-4 demultiplexer: d goes to the output picked by {s1,s0}, the other three are zero.
// Latency: one clk edge from inputs to outputs.
// Backpressure: none; all four outputs reload on every edge.
module demux_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3
);

  logic [1:0] sel;

  assign sel = {s1, s0};

  // Every output has its own flop so the destinations never see select glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      d0 <= '0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else begin
      d0 <= (sel == 2'b00) ? d : '0;
      d1 <= (sel == 2'b01) ? d : '0;
      d2 <= (sel == 2'b10) ? d : '0;
      d3 <= (sel == 2'b11) ? d : '0;
    end
  end

endmodule

// File: tb/tb_demux_1.sv
// Bench for demux_1: an 8-bit instance and a default-width instance driven in lockstep.
module tb_demux_1;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic [0:0] d_n;
  logic       s1;
  logic       s0;
  logic [7:0] w0, w1, w2, w3;
  logic [0:0] n0, n1, n2, n3;

  int n_checks;
  int n_fail;

  logic [31:0] exp_w;
  logic [3:0]  exp_n;

  demux_1 #(.WIDTH(8)) u_dut_w (
    .clk(clk), .rst(rst), .d(d), .s1(s1), .s0(s0),
    .d0(w0), .d1(w1), .d2(w2), .d3(w3)
  );

  demux_1 u_dut_n (
    .clk(clk), .rst(rst), .d(d_n), .s1(s1), .s0(s0),
    .d0(n0), .d1(n1), .d2(n2), .d3(n3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: lane number sel carries d, every other lane is zero; reset clears all lanes.
  function automatic logic [31:0] model_w(input logic r, input logic [7:0] dv, input logic [1:0] sv);
    if (r) return 32'h0;
    return {24'h0, dv} << (8 * int'(sv));
  endfunction

  function automatic logic [3:0] model_n(input logic r, input logic dv, input logic [1:0] sv);
    if (r) return 4'h0;
    return {3'b000, dv} << int'(sv);
  endfunction

  // Apply inputs away from the edge, clock once, sample 1 time unit after the edge.
  task automatic drive(input logic r, input logic [7:0] dv, input logic [1:0] sv);
    rst = r;
    d   = dv;
    d_n = dv[0];
    {s1, s0} = sv;
    @(posedge clk);
    #1;
    exp_w = model_w(r, dv, sv);
    exp_n = model_n(r, dv[0], sv);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h01, 2'b00);
      n_checks++;
      if ({w3, w2, w1, w0} !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h required %h", i, {w3, w2, w1, w0}, 32'h0);
      end
      n_checks++;
      if ({n3, n2, n1, n0} !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_hold_narrow[%0d]: got %b required 0000", i, {n3, n2, n1, n0});
      end
    end
    drive(1'b0, 8'h01, 2'b00);
    n_checks++;
    if ({w3, w2, w1, w0} !== exp_w) begin
      n_fail++;
      $display("FAIL reset_release: got %h required %h", {w3, w2, w1, w0}, exp_w);
    end
    n_checks++;
    if ({n3, n2, n1, n0} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release_narrow: got %b required 0001", {n3, n2, n1, n0});
    end
  endtask

  task automatic test_sweep();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 10; c++) begin
        drive(1'b0, 8'h01, 2'(s));
        n_checks++;
        if ({w3, w2, w1, w0} !== exp_w) begin
          n_fail++;
          $display("FAIL sweep sel=%0d cyc=%0d: got %h required %h", s, c, {w3, w2, w1, w0}, exp_w);
        end
        n_checks++;
        if ({n3, n2, n1, n0} !== exp_n) begin
          n_fail++;
          $display("FAIL sweep_narrow sel=%0d cyc=%0d: got %b required %b", s, c, {n3, n2, n1, n0}, exp_n);
        end
      end
    end
  endtask

  task automatic test_data_zero();
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 8'h00, 2'(s));
      n_checks++;
      if ({w3, w2, w1, w0, n3, n2, n1, n0} !== 36'h0) begin
        n_fail++;
        $display("FAIL data_zero sel=%0d: got %h/%b required 0", s, {w3, w2, w1, w0}, {n3, n2, n1, n0});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b11, 2'b01, 2'b10};
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 8'h01, seq[i]);
        n_checks++;
        if ({w3, w2, w1, w0} !== exp_w) begin
          n_fail++;
          $display("FAIL b2b step=%0d: got %h required %h", i, {w3, w2, w1, w0}, exp_w);
        end
        n_checks++;
        if ($countones({n3, n2, n1, n0}) != 1 || {n3, n2, n1, n0} !== exp_n) begin
          n_fail++;
          $display("FAIL b2b_onehot step=%0d: got %b required %b", i, {n3, n2, n1, n0}, exp_n);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 8'h01, 2'b10);
    n_checks++;
    if (w2 !== 8'h01) begin
      n_fail++;
      $display("FAIL mid_reset_pre: d2 got %h required 01", w2);
    end
    drive(1'b1, 8'h01, 2'b10);
    n_checks++;
    if ({w3, w2, w1, w0} !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_assert: got %h required 0", {w3, w2, w1, w0});
    end
    drive(1'b0, 8'h01, 2'b10);
    n_checks++;
    if ({w3, w2, w1, w0} !== 32'h0001_0000) begin
      n_fail++;
      $display("FAIL mid_reset_release: got %h required 00010000", {w3, w2, w1, w0});
    end
  endtask

  task automatic test_width();
    drive(1'b0, 8'hA5, 2'b01);
    n_checks++;
    if (w1 !== 8'hA5 || w0 !== 8'h00 || w2 !== 8'h00 || w3 !== 8'h00) begin
      n_fail++;
      $display("FAIL width: got d3..d0=%h required 0000a500", {w3, w2, w1, w0});
    end
  endtask

  // Select wiggles between edges must not matter; only the value at the edge counts.
  task automatic test_select_glitch();
    for (int i = 0; i < 8; i++) begin
      logic [1:0] sv;
      logic [7:0] dv;
      sv = 2'($urandom_range(0, 3));
      dv = 8'($urandom);
      rst = 1'b0;
      d = dv;
      d_n = dv[0];
      {s1, s0} = 2'(~sv);
      #2;
      {s1, s0} = 2'(sv + 2'd1);
      #1;
      drive(1'b0, dv, sv);
      n_checks++;
      if ({w3, w2, w1, w0} !== exp_w) begin
        n_fail++;
        $display("FAIL select_glitch[%0d]: got %h required %h", i, {w3, w2, w1, w0}, exp_w);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic       r;
      logic [7:0] dv;
      logic [1:0] sv;
      r  = ($urandom_range(0, 15) == 0);
      dv = 8'($urandom);
      sv = 2'($urandom_range(0, 3));
      drive(r, dv, sv);
      n_checks++;
      if ({w3, w2, w1, w0} !== exp_w) begin
        n_fail++;
        $display("FAIL random[%0d] rst=%0b d=%h sel=%0d: got %h required %h", i, r, dv, sv, {w3, w2, w1, w0}, exp_w);
      end
      n_checks++;
      if ({n3, n2, n1, n0} !== exp_n) begin
        n_fail++;
        $display("FAIL random_narrow[%0d]: got %b required %b", i, {n3, n2, n1, n0}, exp_n);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    d   = 8'h00;
    d_n = 1'b0;
    s1  = 1'b0;
    s0  = 1'b0;
    test_reset();
    test_sweep();
    test_data_zero();
    test_back_to_back();
    test_mid_reset();
    test_width();
    test_select_glitch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
